// File: rtl/line_addr_seq.sv
// Rebuilds line-aligned and per-beat byte addresses from a latched {tag, index} and sequences one cache-line burst.
// Request is issued the cycle after start; beats are counted combinationally on data_ok; done pulses one cycle after the last beat.
module line_addr_seq #(
  parameter int BYTES_PER_LINE = 16,
  parameter int NUM_LINE       = 256,
  parameter int OFFSET_WIDTH   = $clog2(BYTES_PER_LINE),
  parameter int INDEX_WIDTH    = $clog2(NUM_LINE),
  parameter int TAG_WIDTH      = 32 - OFFSET_WIDTH - INDEX_WIDTH
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    is_write,
  input  logic [TAG_WIDTH-1:0]    tag,
  input  logic [INDEX_WIDTH-1:0]  index,
  output logic                    busy,
  output logic                    done,
  output logic                    req,
  output logic                    wr,
  output logic [7:0]              len,
  output logic [31:0]             addr,
  input  logic                    addr_ok,
  input  logic                    data_ok,
  output logic                    beat_valid,
  output logic [OFFSET_WIDTH-1:0] beat_offset,
  output logic [31:0]             beat_addr
);

  localparam int WORDS = BYTES_PER_LINE / 4;
  localparam int CNT_W = OFFSET_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DONE
  } state_t;

  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic                   wr_q;
  logic                   load;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      tag_q   <= '0;
      index_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load) begin
        tag_q   <= tag;
        index_q <= index;
        wr_q    <= is_write;
      end
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    load       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    req        = 1'b0;
    beat_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      REQ: begin
        busy = 1'b1;
        req  = 1'b1;
        if (addr_ok) state_d = DATA;
      end
      DATA: begin
        busy       = 1'b1;
        beat_valid = data_ok;
        if (data_ok) begin
          // Last beat wraps the counter so it never exceeds WORDS-1.
          if (cnt == CNT_W'(WORDS - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr          = wr_q;
  assign len         = 8'(WORDS - 1);
  assign addr        = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
  assign beat_offset = {cnt, 2'b00};
  assign beat_addr   = {tag_q, index_q, beat_offset};

endmodule

// File: tb/tb_line_addr_seq.sv
// Randomized transaction-level bench for line_addr_seq: expected addresses and beat offsets come from the line geometry.
module tb_line_addr_seq;

  localparam int BPL   = 16;
  localparam int NL    = 256;
  localparam int OW    = 4;
  localparam int IW    = 8;
  localparam int TW    = 20;
  localparam int WORDS = BPL / 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          is_write = 1'b0;
  logic          addr_ok = 1'b0;
  logic          data_ok = 1'b0;
  logic [TW-1:0] tag = '0;
  logic [IW-1:0] index = '0;
  logic          busy, done, req, wr, beat_valid;
  logic [7:0]    len;
  logic [31:0]   addr, beat_addr;
  logic [OW-1:0] beat_offset;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_addr_seq #(.BYTES_PER_LINE(BPL), .NUM_LINE(NL)) dut (
    .clk(clk), .resetn(resetn), .start(start), .is_write(is_write),
    .tag(tag), .index(index), .busy(busy), .done(done), .req(req),
    .wr(wr), .len(len), .addr(addr), .addr_ok(addr_ok), .data_ok(data_ok),
    .beat_valid(beat_valid), .beat_offset(beat_offset), .beat_addr(beat_addr)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Start/tag churn while busy must never disturb the latched transfer.
  task automatic noise();
    start    = 1'($urandom);
    tag      = TW'($urandom);
    index    = IW'($urandom);
    is_write = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; addr_ok = 1'($urandom); data_ok = 1'($urandom);
      #1;
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_req",  32'(req), 0);
      chk("idle_bv",   32'(beat_valid), 0);
    end
  endtask

  task automatic xfer(input logic [TW-1:0] t, input logic [IW-1:0] i, input logic w,
                      input int adly, input int gmin, input int gmax);
    logic [31:0] ea;
    int g;
    ea = {t, i, 4'h0};
    @(negedge clk);
    start = 1'b1; tag = t; index = i; is_write = w;
    addr_ok = 1'($urandom); data_ok = 1'($urandom);
    #1;
    chk("start_busy", 32'(busy), 0);
    chk("start_done", 32'(done), 0);
    chk("start_req",  32'(req), 0);
    chk("start_bv",   32'(beat_valid), 0);
    for (int d = 0; d <= adly; d++) begin
      @(negedge clk);
      noise(); addr_ok = (d == adly); data_ok = 1'($urandom);
      #1;
      chk("req",      32'(req), 1);
      chk("req_busy", 32'(busy), 1);
      chk("req_addr", addr, ea);
      chk("req_wr",   32'(wr), 32'(w));
      chk("req_len",  32'(len), WORDS - 1);
      chk("req_bv",   32'(beat_valid), 0);
      chk("req_done", 32'(done), 0);
    end
    for (int k = 0; k < WORDS; k++) begin
      g = $urandom_range(gmax, gmin);
      for (int j = 0; j < g; j++) begin
        @(negedge clk);
        noise(); addr_ok = 1'($urandom); data_ok = 1'b0;
        #1;
        chk("gap_req",  32'(req), 0);
        chk("gap_bv",   32'(beat_valid), 0);
        chk("gap_off",  32'(beat_offset), 4 * k);
        chk("gap_done", 32'(done), 0);
        chk("gap_addr", addr, ea);
      end
      @(negedge clk);
      noise(); addr_ok = 1'($urandom); data_ok = 1'b1;
      #1;
      chk("beat_bv",    32'(beat_valid), 1);
      chk("beat_off",   32'(beat_offset), 4 * k);
      chk("beat_addr",  beat_addr, ea + 4 * k);
      chk("beat_wr",    32'(wr), 32'(w));
      chk("beat_busy",  32'(busy), 1);
      chk("beat_done",  32'(done), 0);
      chk("beat_req",   32'(req), 0);
    end
    @(negedge clk);
    noise(); addr_ok = 1'($urandom); data_ok = 1'($urandom);
    #1;
    chk("done",      32'(done), 1);
    chk("done_busy", 32'(busy), 1);
    chk("done_req",  32'(req), 0);
    chk("done_bv",   32'(beat_valid), 0);
    chk("done_addr", addr, ea);
    start = 1'b0;
  endtask

  task automatic abort_mid_data();
    @(negedge clk);
    start = 1'b1; tag = TW'($urandom); index = IW'($urandom); is_write = 1'b1;
    addr_ok = 1'b0; data_ok = 1'b0;
    @(negedge clk);
    start = 1'b0; addr_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      addr_ok = 1'b0; data_ok = 1'b1;
      #1;
      chk("abort_beat_off", 32'(beat_offset), 4 * k);
    end
    @(negedge clk);
    data_ok = 1'b0; resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1; data_ok = 1'b1; addr_ok = 1'b1;
    #1;
    chk("abort_busy",  32'(busy), 0);
    chk("abort_req",   32'(req), 0);
    chk("abort_done",  32'(done), 0);
    chk("abort_bv",    32'(beat_valid), 0);
    chk("abort_off",   32'(beat_offset), 0);
    chk("abort_addr",  addr, 0);
    chk("abort_wr",    32'(wr), 0);
    chk("abort_baddr", beat_addr, 0);
    @(negedge clk);
    data_ok = 1'b0; addr_ok = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_req",   32'(req), 0);
    chk("rst_bv",    32'(beat_valid), 0);
    chk("rst_addr",  addr, 0);
    chk("rst_off",   32'(beat_offset), 0);
    chk("rst_len",   32'(len), WORDS - 1);
    resetn = 1'b1;

    xfer(20'hABCDE, 8'h5A, 1'b0, 0, 0, 0);
    chk("refill_addr", addr, 32'hABCDE5A0);
    xfer(20'h12345, 8'hC3, 1'b1, 3, 2, 2);
    chk("wb_addr", addr, 32'h12345C30);
    idle(2);
    abort_mid_data();
    xfer(20'h0F0F0, 8'h11, 1'b0, 1, 0, 1);

    for (int n = 0; n < 40; n++) begin
      xfer(TW'($urandom), IW'($urandom), 1'($urandom),
           $urandom_range(4, 0), 0, $urandom_range(3, 0));
      idle($urandom_range(2, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
